// File: rtl/video_pattern_gen.sv
// video_pattern_gen: RGB565 test-pattern renderer (bars, checker, grey ramp,
// bouncing box) with one cycle of latency from the raster coordinates.
module video_pattern_gen #(
    parameter logic [10:0] H_DISP     = 11'd1280,
    parameter logic [10:0] V_DISP     = 11'd720,
    parameter int          NUM_BARS   = 8,
    parameter int          CHK_SHIFT  = 5,
    parameter int          GRAD_SHIFT = 5,
    parameter logic [10:0] BOX_SIZE   = 11'd64
) (
    input  logic        pixel_clk,
    input  logic        sys_rst,
    input  logic        pixel_de,
    input  logic [10:0] pixel_xpos,
    input  logic [10:0] pixel_ypos,
    input  logic [1:0]  mode_sel,
    output logic [15:0] pixel_data,
    output logic        pixel_valid,
    output logic [15:0] frame_cnt
);
    localparam int BAR_W = int'(H_DISP) / NUM_BARS;

    logic [1:0]  mode_q, mode_d;
    logic [10:0] box_x_q, box_x_d;
    logic [10:0] box_y_q, box_y_d;
    logic        dir_x_q, dir_x_d;
    logic        dir_y_q, dir_y_d;
    logic [15:0] pix_q, pix_d;
    logic [15:0] fcnt_q, fcnt_d;
    logic        valid_q;

    logic        frame_start;
    logic        in_range;
    logic        in_box;
    logic [2:0]  bar_idx;
    logic [15:0] bar_rgb;
    logic [10:0] grad_x;
    logic [4:0]  lvl;
    logic [11:0] box_x_end;
    logic [11:0] box_y_end;

    // Returns {dir, pos} after one bounce step; dir=1 means increasing.
    function automatic logic [11:0] next_axis(input logic        dir,
                                              input logic [10:0] pos,
                                              input logic [10:0] lim);
        if (dir && (pos + BOX_SIZE == lim))
            return {1'b0, pos - 11'd1};
        if (!dir && (pos == 11'd0))
            return {1'b1, pos + 11'd1};
        return dir ? {1'b1, pos + 11'd1} : {1'b0, pos - 11'd1};
    endfunction

    assign frame_start = pixel_de && (pixel_xpos == 11'd0)
                         && (pixel_ypos == 11'd0);
    assign in_range    = (pixel_xpos < H_DISP) && (pixel_ypos < V_DISP);

    always_comb begin
        mode_d  = frame_start ? mode_sel : mode_q;
        fcnt_d  = frame_start ? fcnt_q + 16'd1 : fcnt_q;
        {dir_x_d, box_x_d} = {dir_x_q, box_x_q};
        {dir_y_d, box_y_d} = {dir_y_q, box_y_q};
        if (frame_start) begin
            {dir_x_d, box_x_d} = next_axis(dir_x_q, box_x_q, H_DISP);
            {dir_y_d, box_y_d} = next_axis(dir_y_q, box_y_q, V_DISP);
        end
    end

    // Constant boundary compares; the last bar absorbs the remainder.
    always_comb begin
        bar_idx = 3'd0;
        for (int k = 1; k < 8; k++)
            if (k < NUM_BARS && int'(pixel_xpos) >= k * BAR_W)
                bar_idx = 3'(k);
    end

    always_comb begin
        case (bar_idx)
            3'd0:    bar_rgb = 16'hFFFF;
            3'd1:    bar_rgb = 16'hFFE0;
            3'd2:    bar_rgb = 16'h07FF;
            3'd3:    bar_rgb = 16'h07E0;
            3'd4:    bar_rgb = 16'hF81F;
            3'd5:    bar_rgb = 16'hF800;
            3'd6:    bar_rgb = 16'h001F;
            default: bar_rgb = 16'h0000;
        endcase
    end

    assign grad_x    = pixel_xpos >> GRAD_SHIFT;
    assign lvl       = (grad_x > 11'd31) ? 5'd31 : grad_x[4:0];
    assign box_x_end = {1'b0, box_x_q} + {1'b0, BOX_SIZE};
    assign box_y_end = {1'b0, box_y_q} + {1'b0, BOX_SIZE};
    assign in_box    = (pixel_xpos >= box_x_q)
                       && ({1'b0, pixel_xpos} < box_x_end)
                       && (pixel_ypos >= box_y_q)
                       && ({1'b0, pixel_ypos} < box_y_end);

    always_comb begin
        pix_d = 16'h0000;
        if (pixel_de && in_range) begin
            case (mode_d)
                2'd0: pix_d = bar_rgb;
                2'd1: pix_d = (pixel_xpos[CHK_SHIFT] ^ pixel_ypos[CHK_SHIFT])
                              ? 16'h0000 : 16'hFFFF;
                2'd2: pix_d = {lvl, lvl, lvl[4], lvl};
                default: pix_d = in_box ? 16'hF800 : 16'h001F;
            endcase
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (sys_rst) begin
            mode_q  <= 2'd0;
            box_x_q <= 11'd0;
            box_y_q <= 11'd0;
            dir_x_q <= 1'b1;
            dir_y_q <= 1'b1;
            pix_q   <= 16'h0000;
            fcnt_q  <= 16'h0000;
            valid_q <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            box_x_q <= box_x_d;
            box_y_q <= box_y_d;
            dir_x_q <= dir_x_d;
            dir_y_q <= dir_y_d;
            pix_q   <= pix_d;
            fcnt_q  <= fcnt_d;
            valid_q <= pixel_de;
        end
    end

    assign pixel_data  = pix_q;
    assign pixel_valid = valid_q;
    assign frame_cnt   = fcnt_q;
endmodule

// File: tb/tb_video_pattern_gen.sv
// tb_video_pattern_gen: randomized raster stimulus against a closed-form
// pattern model; a NUM_BARS=3 instance shares the same stimulus.
module tb_video_pattern_gen;
    logic        clk = 1'b0;
    logic        rst, de;
    logic [10:0] xp, yp;
    logic [1:0]  msel;
    logic [15:0] pd, pd3, fc, fc3;
    logic        pv, pv3;

    int          n_chk  = 0;
    int          n_fail = 0;
    int          m_mode = 0;
    int          m_upd  = 0;
    logic [15:0] m_fcnt = 16'h0;

    always #5 clk = ~clk;

    video_pattern_gen dut (
        .pixel_clk(clk), .sys_rst(rst), .pixel_de(de),
        .pixel_xpos(xp), .pixel_ypos(yp), .mode_sel(msel),
        .pixel_data(pd), .pixel_valid(pv), .frame_cnt(fc)
    );

    video_pattern_gen #(.NUM_BARS(3)) dut3 (
        .pixel_clk(clk), .sys_rst(rst), .pixel_de(de),
        .pixel_xpos(xp), .pixel_ypos(yp), .mode_sel(msel),
        .pixel_data(pd3), .pixel_valid(pv3), .frame_cnt(fc3)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Box position after n bounce updates: triangle wave over 0..lim-64.
    function automatic int tri_pos(input int n, input int lim);
        int r, m;
        r = lim - 64;
        m = n % (2 * r);
        return (m <= r) ? m : 2 * r - m;
    endfunction

    function automatic logic [15:0] ref_pix(input int mode, input int x,
                                            input int y, input int nb,
                                            input int nupd);
        logic [15:0] pal [0:7];
        int idx, l, bx, by;
        pal = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                16'hF81F, 16'hF800, 16'h001F, 16'h0000};
        if (x >= 1280 || y >= 720) return 16'h0000;
        case (mode)
            0: begin
                idx = x / (1280 / nb);
                if (idx > nb - 1) idx = nb - 1;
                return pal[idx];
            end
            1: return (((x / 32) + (y / 32)) % 2 == 0) ? 16'hFFFF : 16'h0000;
            2: begin
                l = x / 32;
                if (l > 31) l = 31;
                return 16'(l * 2048 + l * 64 + (l / 16) * 32 + l);
            end
            default: begin
                bx = tri_pos(nupd, 1280);
                by = tri_pos(nupd, 720);
                return (x >= bx && x < bx + 64 && y >= by && y < by + 64)
                       ? 16'hF800 : 16'h001F;
            end
        endcase
    endfunction

    task automatic step(input bit r, input bit d, input int x, input int y,
                        input int ms, input string tag);
        logic [15:0] e_pix, e_pix3;
        logic        e_val;
        bit          fs;
        if (r) begin
            m_mode = 0;
            m_upd  = 0;
            m_fcnt = 16'h0;
            e_pix  = 16'h0;
            e_pix3 = 16'h0;
            e_val  = 1'b0;
        end else begin
            fs = d && x == 0 && y == 0;
            if (fs) m_mode = ms;
            e_pix  = d ? ref_pix(m_mode, x, y, 8, m_upd) : 16'h0;
            e_pix3 = d ? ref_pix(m_mode, x, y, 3, m_upd) : 16'h0;
            e_val  = d;
            if (fs) begin
                m_upd++;
                m_fcnt++;
            end
        end
        rst  = r;
        de   = d;
        xp   = 11'(x);
        yp   = 11'(y);
        msel = 2'(ms);
        @(posedge clk);
        #1;
        chk({tag, "_data"}, 32'(pd), 32'(e_pix));
        chk({tag, "_data3"}, 32'(pd3), 32'(e_pix3));
        chk({tag, "_valid"}, 32'(pv), 32'(e_val));
        chk({tag, "_fcnt"}, 32'(fc), 32'(m_fcnt));
    endtask

    task automatic rand_pixels(input int n, input string tag);
        for (int i = 0; i < n; i++)
            step(0, ($urandom_range(0, 7) != 0), $urandom_range(1, 1400),
                 $urandom_range(0, 800), $urandom_range(0, 3), tag);
    endtask

    initial begin
        int bx, by;
        rst = 1'b1; de = 1'b0; xp = '0; yp = '0; msel = '0;

        step(1, 1, 0, 0, 2, "rst_fs");
        step(1, 0, 5, 5, 0, "rst");

        step(0, 1, 0, 0, 0, "bars");
        for (int x = 1; x < 1280; x++) step(0, 1, x, 0, 0, "bars");
        step(0, 0, 10, 0, 0, "de_low");

        for (int x = 490; x < 510; x++)
            step(0, 1, x, 100, (x < 500) ? 0 : 1, "mode_hold");
        rand_pixels(40, "mode_hold");
        step(0, 1, 0, 0, 1, "chk_fs");
        step(0, 1, 32, 0, 2, "chk");
        step(0, 1, 32, 32, 2, "chk");
        step(0, 1, 0, 32, 2, "chk");

        step(0, 1, 0, 0, 2, "grad_fs");
        step(0, 1, 33, 0, 0, "grad");
        step(0, 1, 1279, 5, 0, "grad");
        step(0, 1, 1000, 700, 0, "grad");

        step(0, 1, 1280, 10, 0, "oob");
        step(0, 1, 10, 720, 0, "oob");
        step(0, 1, 2047, 2047, 0, "oob");

        for (int f = 0; f < 20; f++) begin
            step(0, 1, 0, 0, $urandom_range(0, 3), "rnd_fs");
            rand_pixels(100, "rnd");
        end

        step(1, 0, 0, 0, 0, "rst2");
        for (int f = 0; f < 5; f++) begin
            step(0, 1, 0, 0, 2, "pre_fs");
            rand_pixels(5, "pre");
        end
        step(0, 1, 699, 300, 1, "pre_rst");
        step(1, 1, 700, 300, 1, "mid_rst");
        step(0, 1, 701, 300, 2, "post_rst");
        step(0, 1, 0, 0, 2, "post_fs");

        step(1, 0, 0, 0, 0, "rst3");
        for (int f = 0; f < 1220; f++) begin
            step(0, 1, 0, 0, 3, "box_fs");
            bx = tri_pos(m_upd, 1280);
            by = tri_pos(m_upd, 720);
            step(0, 1, bx, by, $urandom_range(0, 3), "box_in");
            step(0, 1, bx + 63, by + 63, $urandom_range(0, 3), "box_in");
            step(0, 1, bx + 64, by, $urandom_range(0, 3), "box_xr");
            step(0, 1, bx, by + 64, $urandom_range(0, 3), "box_yb");
            if (bx > 0) step(0, 1, bx - 1, by, 0, "box_xl");
            if (by > 0) step(0, 1, bx, by - 1, 0, "box_yt");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
